half_narrow_tx: RTL and testbench

Narrowing transmitter that converts 32-bit words into 16-bit beats. It is the opposite direction of the sign-extension path: each accepted word leaves either as one narrowed halfword, checked against sign-extension, or as two raw halfwords sent low then high. It sits between the 32-bit datapath and any 16-bit sink, such as a halfword store port or a 16-bit link. Both sides use valid/ready handshakes.

---
 rtl/half_narrow_tx.sv | 107 ++++++++++
 tb/tb_half_narrow_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/half_narrow_tx.sv
// 32-to-16 bit narrowing transmitter. Each accepted word leaves either as one
// narrowed halfword (overflow-checked, optionally saturated) or as two raw halfwords, low first.
module half_narrow_tx #(
   parameter int unsigned SAT   = 0,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      data_i,
   input  logic             mode_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [15:0]      data_o,
   output logic             last_o,
   output logic             ovf_o,
   output logic [CNT_W-1:0] ovf_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_LO    = 2'd1,
      ST_HI    = 2'd2
   } state_e;

   state_e           state_q;
   logic             valid_q;
   logic             mode_q;
   logic             last_q;
   logic             ovf_q;
   logic [15:0]      data_q;
   logic [15:0]      hi_q;
   logic [CNT_W-1:0] cnt_q;

   logic             accept;
   logic             complete;
   logic             go_hi;
   logic             word_ovf;
   logic [15:0]      first_d;
   logic             last_d;
   logic             ovf_d;

   // Handshake: a word transfers on in_valid_i && in_ready_o, a beat on
   // out_valid_o && out_ready_i. A new word may enter while the last beat leaves.
   assign in_ready_o = !rst_i && (!valid_q || (out_ready_i && last_q));
   assign accept     = in_valid_i && in_ready_o;
   assign complete   = valid_q && out_ready_i;
   assign go_hi      = complete && (state_q == ST_LO) && mode_q;

   // First beat of an incoming word: narrow beats are overflow-checked against sign extension.
   always_comb begin
      word_ovf = (data_i[31:16] != {16{data_i[15]}});
      first_d  = data_i[15:0];
      last_d   = !mode_i;
      ovf_d    = !mode_i && word_ovf;
      if (!mode_i && word_ovf && (SAT != 0)) begin
         first_d = data_i[31] ? 16'h8000 : 16'h7FFF;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
         valid_q <= 1'b0;
         mode_q  <= 1'b0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
         data_q  <= 16'h0000;
         hi_q    <= 16'h0000;
         cnt_q   <= '0;
      end else begin
         if (complete && ovf_q && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         // accept can only coincide with an empty slot or the final beat leaving,
         // so it never competes with the LO->HI step.
         if (accept) begin
            state_q <= ST_LO;
            valid_q <= 1'b1;
            mode_q  <= mode_i;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            data_q  <= first_d;
            hi_q    <= data_i[31:16];
         end else if (go_hi) begin
            state_q <= ST_HI;
            last_q  <= 1'b1;
            ovf_q   <= 1'b0;
            data_q  <= hi_q;
         end else if (complete) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            data_q  <= 16'h0000;
         end
      end
   end

   assign out_valid_o = valid_q;
   assign data_o      = data_q;
   assign last_o      = last_q;
   assign ovf_o       = ovf_q;
   assign ovf_cnt_o   = cnt_q;

endmodule

// File: tb/tb_half_narrow_tx.sv
// Bench for half_narrow_tx: three parameterisations share one stimulus stream and
// are compared each cycle against a beat-queue reference model.
module tb_half_narrow_tx;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i;
   logic        in_valid_i;
   logic [31:0] data_i;
   logic        mode_i;
   logic        out_ready_i;

   logic        in_ready_a, out_valid_a, last_a, ovf_a;
   logic [15:0] data_a;
   logic [7:0]  cnt_a;
   logic        in_ready_b, out_valid_b, last_b, ovf_b;
   logic [15:0] data_b;
   logic [7:0]  cnt_b;
   logic        in_ready_c, out_valid_c, last_c, ovf_c;
   logic [15:0] data_c;
   logic [1:0]  cnt_c;

   half_narrow_tx #(.SAT(0), .CNT_W(8)) u_trunc (
      .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_a),
      .data_i(data_i), .mode_i(mode_i), .out_valid_o(out_valid_a), .out_ready_i(out_ready_i),
      .data_o(data_a), .last_o(last_a), .ovf_o(ovf_a), .ovf_cnt_o(cnt_a));

   half_narrow_tx #(.SAT(1), .CNT_W(8)) u_sat (
      .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_b),
      .data_i(data_i), .mode_i(mode_i), .out_valid_o(out_valid_b), .out_ready_i(out_ready_i),
      .data_o(data_b), .last_o(last_b), .ovf_o(ovf_b), .ovf_cnt_o(cnt_b));

   half_narrow_tx #(.SAT(0), .CNT_W(2)) u_cnt2 (
      .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_c),
      .data_i(data_i), .mode_i(mode_i), .out_valid_o(out_valid_c), .out_ready_i(out_ready_i),
      .data_o(data_c), .last_o(last_c), .ovf_o(ovf_c), .ovf_cnt_o(cnt_c));

   typedef struct {
      logic [15:0] d_trunc;
      logic [15:0] d_sat;
      logic        last;
      logic        ovf;
   } beat_t;

   beat_t exp_q[$];
   int    ovf_total = 0;
   int    n_vec = 0;
   int    n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Beats a word produces, from its signed value rather than bit patterns.
   task automatic push_word(input logic [31:0] d, input logic m);
      beat_t b;
      int    v;
      bit    fits;
      v    = int'($signed(d));
      fits = (v >= -32768) && (v <= 32767);
      if (!m) begin
         b.d_trunc = d[15:0];
         b.d_sat   = fits ? d[15:0] : ((v < 0) ? 16'h8000 : 16'h7FFF);
         b.last    = 1'b1;
         b.ovf     = !fits;
         exp_q.push_back(b);
      end else begin
         b.d_trunc = d[15:0];
         b.d_sat   = d[15:0];
         b.last    = 1'b0;
         b.ovf     = 1'b0;
         exp_q.push_back(b);
         b.d_trunc = d[31:16];
         b.d_sat   = d[31:16];
         b.last    = 1'b1;
         exp_q.push_back(b);
      end
   endtask

   // One clock: drive at the falling edge, check, then advance the model at the rising edge.
   task automatic step(input logic r, input logic v, input logic [31:0] d, input logic m,
                       input logic rdy);
      bit exp_valid;
      bit exp_ready;
      int c8;
      int c2;
      @(negedge clk);
      rst_i = r; in_valid_i = v; data_i = d; mode_i = m; out_ready_i = rdy;
      #1;
      exp_valid = (exp_q.size() != 0);
      exp_ready = !r && (!exp_valid || (rdy && exp_q[0].last));
      c8 = (ovf_total > 255) ? 255 : ovf_total;
      c2 = (ovf_total > 3) ? 3 : ovf_total;
      check_eq("in_ready_trunc", 32'(in_ready_a), 32'(exp_ready));
      check_eq("in_ready_sat", 32'(in_ready_b), 32'(exp_ready));
      check_eq("in_ready_cnt2", 32'(in_ready_c), 32'(exp_ready));
      check_eq("out_valid_trunc", 32'(out_valid_a), 32'(exp_valid));
      check_eq("out_valid_sat", 32'(out_valid_b), 32'(exp_valid));
      check_eq("out_valid_cnt2", 32'(out_valid_c), 32'(exp_valid));
      check_eq("cnt_trunc", 32'(cnt_a), 32'(c8));
      check_eq("cnt_sat", 32'(cnt_b), 32'(c8));
      check_eq("cnt_cnt2", 32'(cnt_c), 32'(c2));
      if (exp_valid) begin
         check_eq("data_trunc", 32'(data_a), 32'(exp_q[0].d_trunc));
         check_eq("data_sat", 32'(data_b), 32'(exp_q[0].d_sat));
         check_eq("data_cnt2", 32'(data_c), 32'(exp_q[0].d_trunc));
         check_eq("last_trunc", 32'(last_a), 32'(exp_q[0].last));
         check_eq("last_sat", 32'(last_b), 32'(exp_q[0].last));
         check_eq("ovf_trunc", 32'(ovf_a), 32'(exp_q[0].ovf));
         check_eq("ovf_sat", 32'(ovf_b), 32'(exp_q[0].ovf));
         check_eq("ovf_cnt2", 32'(ovf_c), 32'(exp_q[0].ovf));
      end
      @(posedge clk);
      if (r) begin
         exp_q.delete();
         ovf_total = 0;
      end else begin
         if (exp_valid && rdy) begin
            if (exp_q[0].ovf) ovf_total++;
            void'(exp_q.pop_front());
         end
         if (v && exp_ready) push_word(d, m);
      end
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 1'b0, 32'h0, 1'b0, rdy);
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      logic [31:0] edges[6];
      edges[0] = 32'h00007FFF; edges[1] = 32'hFFFF8000; edges[2] = 32'h00008000;
      edges[3] = 32'hFFFF7FFF; edges[4] = 32'h80000000; edges[5] = 32'h7FFFFFFF;
      case ($urandom_range(0, 2))
         0:       w = $urandom();
         1:       w = 32'($signed(16'($urandom())));
         default: w = edges[$urandom_range(0, 5)];
      endcase
      return w;
   endfunction

   initial begin
      rst_i = 1'b1; in_valid_i = 1'b0; data_i = 32'h0; mode_i = 1'b0; out_ready_i = 1'b0;
      step(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      idle(1'b0);

      // Narrow without and with overflow, including the negative saturation bound.
      step(1'b0, 1'b1, 32'hFFFF8001, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h00012345, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Split word held under backpressure, with a competing word waiting.
      step(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h00000011, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h00000011, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h00000011, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Eight back-to-back narrow words, then a mixed stream.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'(i * 32'h11111), 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'hA5A50000 + 32'(i), 1'(i % 2), 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Reset while the HI beat of a split word is pending.
      step(1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Counter saturation: five overflowing narrow words from a cleared counter.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h00012345, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 3) != 0), rand_word(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 4; i++) idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
